timer_bus_initiator: RTL and testbench
======================================

// Module: timer_bus_initiator
// PURPOSE
//  Autonomous bus initiator for the 4-bit-address timer peripheral register map.
//  Drives that peripheral's cs_n/rd_n/wr_n/addr/data interface in place of the Z80:
//   - programs the 32-bit delay and starts the timer;
//   - polls BUSY until the timer expires;
//   - reports completion as a one-cycle pulse.
//  Lets fabric logic request hardware delays without CPU involvement.
// PARAMETERS
//  POLL_GAP  4       idle cycles between consecutive BUSY reads (>=1)
//  POLL_MAX  16'hFFFF max BUSY reads per request before abort; 0 = unlimited
// PORTS
//  clk          in   1   single clock; all logic rising-edge
//  reset        in   1   synchronous, active-high reset
//  req_valid    in   1   delay request valid
//  req_delay    in   32  delay in clk cycles; sampled on accept
//  req_ready    out  1   high in IDLE only; accept = req_valid & req_ready
//  done         out  1   1-cycle pulse: timer expired
//  err          out  1   1-cycle pulse: POLL_MAX exceeded, request aborted
//  stamp        out  32  timer NOW value captured at completion (TIMESTAMP_EN)
//  stamp_valid  out  1   1-cycle pulse with stamp (TIMESTAMP_EN)
//  bus_cs_n     out  1   peripheral chip select, active low
//  bus_rd_n     out  1   read strobe, active low
//  bus_wr_n     out  1   write strobe, active low
//  bus_addr     out  4   register address: DEL0-3=0-3, CFG=4, BUSY=5, NOW0-3=6-9
//  bus_wdata    out  8   write data
//  bus_rdata    in   8   read data; combinational from peripheral
// BEHAVIOUR
//  Reset values: bus_cs_n/rd_n/wr_n=1, bus_addr=0, bus_wdata=0, req_ready=0,
//   done=0, err=0, stamp=0, stamp_valid=0. State = CLR.
//  Bus access: exactly 1 strobe cycle, registered outputs.
//   - write: cs_n=0, wr_n=0, rd_n=1.
//   - read: cs_n=0, rd_n=0, wr_n=1; bus_rdata sampled at end of the strobe cycle.
//   - every access is followed by >=1 cycle with all strobes high.
//  CFG bits: [0] enable, [1] start, [2] capture NOW.
//  States and transitions:
//   CLR      write CFG=0x00 -> EN. Clears stale peripheral busy/deadline.
//   EN       write CFG=0x01 -> IDLE.
//   IDLE     req_ready=1. On accept: latch req_delay.
//            delay==0 -> DONE; no bus traffic.
//            else -> WR_DEL.
//   WR_DEL   write DEL0..DEL3 = delay[7:0]..[31:24], LSB first -> WR_START.
//   WR_START write CFG=0x03 -> SETTLE.
//   SETTLE   2 idle cycles; covers the peripheral's registered start/busy latency -> POLL_RD.
//   POLL_RD  read BUSY; poll count +1.
//            rdata[0]==0 -> DONE.
//            else -> POLL_WAIT.
//   POLL_WAIT POLL_GAP idle cycles.
//            poll count==POLL_MAX (POLL_MAX!=0) -> ABORT.
//            else -> POLL_RD.
//   DONE     done=1 for 1 cycle -> IDLE, or -> TS_CAP when TIMESTAMP_EN.
//   ABORT    err=1 for 1 cycle -> CLR; re-init, no done pulse.
//  Accept-to-first-strobe latency: 1 cycle. Zero-delay accept-to-done: 1 cycle.
//  Poll counter: 16-bit, cleared on accept, saturates at all ones.
//  Deadlines accumulate in the peripheral (deadline += delay), so back-to-back
//   requests are phase-locked to the previous deadline.
//  req_valid outside IDLE is ignored; requests are never queued.
//  Reset asserted mid-access: strobes high on the next edge.
//   Restart always via CLR, so the peripheral is re-synchronised.
//  done and err are never asserted in the same cycle.
// CONFIGURATION
//  TIMESTAMP_EN defined:
//   - DONE -> TS_CAP: write CFG=0x05, then 1 idle cycle.
//   - TS_RD: read NOW0..NOW3 into stamp[7:0]..[31:24].
//   - stamp_valid=1 for 1 cycle, then IDLE.
//   - Zero-delay requests also capture.
//  TIMESTAMP_EN undefined:
//   - TS states absent; stamp=0 and stamp_valid=0 constantly.
//   - DONE -> IDLE.
// TESTING
//  1 Reset 3 cycles, release -> writes CFG=0x00 then CFG=0x01; req_ready=1 by cycle 5.
//  2 req_delay=32'h0000_0040 with peripheral model ->
//    writes DEL0=0x40, DEL1-3=0x00, CFG=0x03; BUSY polled;
//    done pulses once, within POLL_GAP+2 cycles of expiry.
//  3 req_delay=0 -> done 1 cycle after accept; cs_n stays high.
//  4 POLL_MAX=3, BUSY held at 1 -> exactly 3 BUSY reads; err pulse;
//    CFG=0x00 then CFG=0x01; done never asserted.
//  5 reset asserted during WR_DEL (DEL1 strobe) -> strobes high next cycle;
//    after release, sequence restarts at CFG=0x00.
//  6 TIMESTAMP_EN, model NOW=32'h1234_5678 -> CFG=0x05, reads at addr 6-9;
//    stamp=32'h1234_5678 with stamp_valid one cycle.

Source files
------------

// File: rtl/timer_bus_initiator.sv
// timer_bus_initiator: bus master that programs, starts and polls the timer peripheral. Define TIMESTAMP_EN to capture NOW at completion.
module timer_bus_initiator #(
  parameter int          POLL_GAP = 4,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_delay,
  output logic        req_ready,
  output logic        done,
  output logic        err,
  output logic [31:0] stamp,
  output logic        stamp_valid,
  output logic        bus_cs_n,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic [3:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);
  typedef enum logic [3:0] {CLR, EN, IDLE, WR_DEL, WR_START, SETTLE, POLL_RD, POLL_WAIT, DONE, ABORT
`ifdef TIMESTAMP_EN
    , TS_CAP, TS_RD, TS_VLD
`endif
  } state_t;
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
  state_t state, nxt;
  logic [15:0] cnt, ncnt, polls;
  logic [31:0] delay, dly_src;
  logic cs_d, rd_d, wr_d, accept;
  logic [3:0] addr_d;
  logic [7:0] wdata_d;
  assign req_ready = state == IDLE;
  assign done = state == DONE;
  assign err = state == ABORT;
  assign accept = req_valid && req_ready;
  assign dly_src = accept ? req_delay : delay;
  always_comb begin
    nxt = state;
    ncnt = cnt + 16'd1;
    case (state)
      CLR:       if (cnt == 16'd2) begin nxt = EN; ncnt = '0; end
      EN:        if (cnt == 16'd1) begin nxt = IDLE; ncnt = '0; end
      IDLE:      begin ncnt = '0; if (accept) nxt = (req_delay == '0) ? DONE : WR_DEL; end
      WR_DEL:    if (cnt == 16'd7) begin nxt = WR_START; ncnt = '0; end
      WR_START:  begin nxt = SETTLE; ncnt = '0; end
      SETTLE:    if (cnt == 16'd1) begin nxt = POLL_RD; ncnt = '0; end
      POLL_RD:   begin nxt = bus_rdata[0] ? POLL_WAIT : DONE; ncnt = '0; end
      POLL_WAIT: if (cnt == GAP_LAST) begin nxt = (POLL_MAX != '0 && polls == POLL_MAX) ? ABORT : POLL_RD; ncnt = '0; end
`ifdef TIMESTAMP_EN
      DONE:      begin nxt = TS_CAP; ncnt = '0; end
      TS_CAP:    if (cnt == 16'd1) begin nxt = TS_RD; ncnt = '0; end
      TS_RD:     if (cnt == 16'd7) begin nxt = TS_VLD; ncnt = '0; end
      TS_VLD:    begin nxt = IDLE; ncnt = '0; end
`else
      DONE:      begin nxt = IDLE; ncnt = '0; end
`endif
      ABORT:     begin nxt = CLR; ncnt = '0; end
      default:   begin nxt = CLR; ncnt = '0; end
    endcase
  end
  // Strobes are decoded from the upcoming state so the registered bus lines up with it.
  always_comb begin
    cs_d = 1'b1;
    rd_d = 1'b1;
    wr_d = 1'b1;
    addr_d = '0;
    wdata_d = '0;
    case (nxt)
      CLR:      if (ncnt == 16'd1) begin cs_d = 1'b0; wr_d = 1'b0; addr_d = 4'd4; end
      EN:       if (ncnt == 16'd0) begin cs_d = 1'b0; wr_d = 1'b0; addr_d = 4'd4; wdata_d = 8'h01; end
      WR_DEL:   if (!ncnt[0]) begin cs_d = 1'b0; wr_d = 1'b0; addr_d = {2'b00, ncnt[2:1]}; wdata_d = 8'(dly_src >> {ncnt[2:1], 3'b000}); end
      WR_START: begin cs_d = 1'b0; wr_d = 1'b0; addr_d = 4'd4; wdata_d = 8'h03; end
      POLL_RD:  begin cs_d = 1'b0; rd_d = 1'b0; addr_d = 4'd5; end
`ifdef TIMESTAMP_EN
      TS_CAP:   if (ncnt == 16'd0) begin cs_d = 1'b0; wr_d = 1'b0; addr_d = 4'd4; wdata_d = 8'h05; end
      TS_RD:    if (!ncnt[0]) begin cs_d = 1'b0; rd_d = 1'b0; addr_d = 4'd6 + {2'b00, ncnt[2:1]}; end
`endif
      default:  ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLR;
      cnt <= '0;
      polls <= '0;
      delay <= '0;
      bus_cs_n <= 1'b1;
      bus_rd_n <= 1'b1;
      bus_wr_n <= 1'b1;
      bus_addr <= '0;
      bus_wdata <= '0;
    end else begin
      state <= nxt;
      cnt <= ncnt;
      bus_cs_n <= cs_d;
      bus_rd_n <= rd_d;
      bus_wr_n <= wr_d;
      bus_addr <= addr_d;
      bus_wdata <= wdata_d;
      if (accept) begin
        delay <= req_delay;
        polls <= '0;
      end else if (state == POLL_RD && polls != '1) polls <= polls + 16'd1;
    end
  end
`ifdef TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset) stamp <= '0;
    else if (state == TS_RD && !cnt[0]) stamp[{cnt[2:1], 3'b000} +: 8] <= bus_rdata;
  end
  assign stamp_valid = state == TS_VLD;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus_rdata[7:1];
  assign stamp = '0;
  assign stamp_valid = 1'b0;
`endif
endmodule

// File: tb/tb_timer_bus_initiator.sv
// tb_timer_bus_initiator: scoreboard bench with a behavioural timer peripheral and randomized delay requests.
module tb_timer_bus_initiator;
  localparam int GAP = 4;
  localparam logic [15:0] PMAX = 16'd20;
  localparam logic [2:0] K_W = 3'd0, K_R = 3'd1, K_DONE = 3'd2, K_ERR = 3'd3, K_STAMP = 3'd4;
  typedef struct packed {logic [2:0] kind; logic [3:0] addr; logic [7:0] data;} tok_t;

  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
  logic [31:0] req_delay = '0;
  logic req_ready, done, err, stamp_valid, bus_cs_n, bus_rd_n, bus_wr_n;
  logic [31:0] stamp;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;

  timer_bus_initiator #(.POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_delay(req_delay),
    .req_ready(req_ready), .done(done), .err(err), .stamp(stamp), .stamp_valid(stamp_valid),
    .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  tok_t exp_q[$];

  // Timer peripheral: NOW free-runs, deadlines accumulate while armed, CFG enable=0 disarms.
  logic [7:0] dreg [4] = '{default: 8'h00};
  logic [31:0] cyc = 32'h1234_5000, deadline = '0, now_cap = '0;
  logic armed = 1'b0, force_busy = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (!bus_cs_n && !bus_wr_n) begin
      if (bus_addr < 4'd4) dreg[bus_addr[1:0]] <= bus_wdata;
      else if (bus_addr == 4'd4) begin
        if (!bus_wdata[0]) begin
          armed <= 1'b0;
          deadline <= cyc;
        end else begin
          if (bus_wdata[1]) begin
            deadline <= (armed ? deadline : cyc) + {dreg[3], dreg[2], dreg[1], dreg[0]};
            armed <= 1'b1;
          end
          if (bus_wdata[2]) now_cap <= cyc;
        end
      end
    end
  end
  always_comb begin
    bus_rdata = 8'h00;
    if (!bus_cs_n && !bus_rd_n) begin
      if (bus_addr == 4'd5) bus_rdata = {7'd0, force_busy || (cyc < deadline)};
      else if (bus_addr >= 4'd6 && bus_addr <= 4'd9) bus_rdata = 8'(now_cap >> (8 * (int'(bus_addr) - 6)));
    end
  end

  function automatic tok_t tk(input logic [2:0] k, input logic [3:0] a, input logic [7:0] d);
    tok_t t;
    t.kind = k;
    t.addr = a;
    t.data = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic expect_tok(input tok_t t, input string what);
    tok_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got kind=%0d addr=%0d data=%02h with nothing expected", what, t.kind, t.addr, t.data);
    end else begin
      e = exp_q.pop_front();
      if (e != t) begin
        errors++;
        $display("FAIL %s: got kind=%0d addr=%0d data=%02h want kind=%0d addr=%0d data=%02h",
                 what, t.kind, t.addr, t.data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: compares every observed transaction against the scoreboard queue.
  int reads = 0;
  logic [31:0] first_rd = '0, ref_t;
  logic prev_strobe = 1'b0, strobe, nz = 1'b0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      reads = 0;
      prev_strobe = 1'b0;
    end else begin
      strobe = !bus_cs_n && (!bus_rd_n || !bus_wr_n);
      if (strobe) begin
        checks++;
        if (prev_strobe || (!bus_rd_n && !bus_wr_n)) begin
          errors++;
          $display("FAIL strobe_spacing: back-to-back or dual strobe at addr %0d rd_n=%0b wr_n=%0b", bus_addr, bus_rd_n, bus_wr_n);
        end
      end
      prev_strobe = strobe;
      if (!bus_cs_n && !bus_wr_n) expect_tok(tk(K_W, bus_addr, bus_wdata), "bus_write");
      if (!bus_cs_n && !bus_rd_n) begin
        if (bus_addr == 4'd5) begin
          if (reads == 0) first_rd = cyc;
          reads++;
        end else expect_tok(tk(K_R, bus_addr, 8'h00), "bus_read");
      end
      if (done || err) chk("done_err_exclusive", {31'd0, done && err}, 32'd0);
      if (done) begin
        expect_tok(tk(K_DONE, 4'd0, 8'h00), "done_pulse");
        if (nz) begin
          ref_t = (deadline > first_rd) ? deadline : first_rd;
          checks++;
          if (reads == 0 || cyc <= ref_t || cyc - ref_t > GAP + 2) begin
            errors++;
            $display("FAIL done_window: done at %0d, expiry %0d, busy reads %0d", cyc, ref_t, reads);
          end
        end
        reads = 0;
      end
      if (err) begin
        expect_tok(tk(K_ERR, 4'd0, 8'h00), "err_pulse");
        chk("abort_reads", reads, 32'(PMAX));
        reads = 0;
      end
      if (stamp_valid) begin
        expect_tok(tk(K_STAMP, 4'd0, 8'h00), "stamp_pulse");
        chk("stamp_value", stamp, now_cap);
      end
    end
  end

  task automatic push_init();
    exp_q.push_back(tk(K_W, 4'd4, 8'h00));
    exp_q.push_back(tk(K_W, 4'd4, 8'h01));
  endtask

  task automatic push_req(input logic [31:0] d, input bit abort);
    if (d != 0) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(tk(K_W, 4'(i), 8'(d >> (8 * i))));
      exp_q.push_back(tk(K_W, 4'd4, 8'h03));
    end
    if (abort) begin
      exp_q.push_back(tk(K_ERR, 4'd0, 8'h00));
      push_init();
    end else begin
      exp_q.push_back(tk(K_DONE, 4'd0, 8'h00));
`ifdef TIMESTAMP_EN
      exp_q.push_back(tk(K_W, 4'd4, 8'h05));
      for (int i = 0; i < 4; i++) exp_q.push_back(tk(K_R, 4'(6 + i), 8'h00));
      exp_q.push_back(tk(K_STAMP, 4'd0, 8'h00));
`endif
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain: %0d expected events left, req_ready=%0b after %0d cycles", exp_q.size(), req_ready, n);
      exp_q.delete();
    end
  endtask

  task automatic request(input logic [31:0] d, input bit abort);
    nz = (d != 0);
    push_req(d, abort);
    req_valid = 1'b1;
    req_delay = d;
    @(posedge clk); #1;
    if (d == 0) chk("zero_delay_done", {30'd0, done, bus_cs_n}, 32'd3);
    else chk("first_strobe", {20'd0, bus_cs_n, bus_wr_n, bus_rd_n, bus_addr, bus_wdata}, {20'd0, 3'b001, 4'd0, d[7:0]});
    req_delay = ~d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain(600);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] d;
    push_init();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus", {17'd0, bus_cs_n, bus_rd_n, bus_wr_n, bus_addr, bus_wdata}, {17'd0, 3'b111, 12'h000});
    chk("reset_flags", {28'd0, req_ready, done, err, stamp_valid}, 32'd0);
    chk("reset_stamp", stamp, 32'd0);
    reset = 1'b0;
    n = 0;
    while (!req_ready && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_by_5", {31'd0, req_ready}, 32'd1);
    drain(20);
    request(32'h0000_0040, 1'b0);
    request(32'h0000_0000, 1'b0);
    force_busy = 1'b1;
    request(32'h0000_0100 + 32'($urandom_range(1, 200)), 1'b1);
    force_busy = 1'b0;
    nz = 1'b1;
    push_req(32'hA5C3_7E19, 1'b0);
    req_valid = 1'b1;
    req_delay = 32'hA5C3_7E19;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!(!bus_cs_n && !bus_wr_n && bus_addr == 4'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("del1_strobe", {20'd0, bus_addr, bus_wdata}, {20'd0, 4'd1, 8'h7E});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_access", {29'd0, bus_cs_n, bus_rd_n, bus_wr_n}, 32'd7);
    exp_q.delete();
    push_init();
    @(posedge clk); #1;
    reset = 1'b0;
    drain(50);
    for (int i = 0; i < 14; i++) begin
      d = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      request(d, 1'b0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 30)) @(posedge clk);
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
